// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, RW encoding,
// requester ids and the round-robin grant decision.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // On a tie the requester that was not served last wins.
    function automatic req_id_t pick_grant(input logic if_req, input logic dm_req,
                                           input req_id_t last_gnt);
        req_id_t winner;
        if (if_req && dm_req) begin
            if (last_gnt == REQ_IF) winner = REQ_DM;
            else                    winner = REQ_IF;
        end else if (dm_req) begin
            winner = REQ_DM;
        end else begin
            winner = REQ_IF;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and debug signals of the memory port arbiter.
// Handshake: a requester raises req with stable addr/data and holds it until
// its one-cycle done pulse; the memory answers a held mem_enable with mem_moc.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_rw;
    logic              dm_byte;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_enable;
    logic              mem_rw;
    logic              mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_moc;

    logic              err_timeout;
    state_t            dbg_state;

    modport master (
        output if_req, if_addr, dm_req, dm_rw, dm_byte, dm_addr, dm_wdata,
               mem_rdata, mem_moc,
        input  if_done, if_rdata, dm_done, dm_rdata, mem_enable, mem_rw,
               mem_byte, mem_addr, mem_wdata, err_timeout, dbg_state
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_rw, dm_byte, dm_addr, dm_wdata,
               mem_rdata, mem_moc,
        output if_done, if_rdata, dm_done, dm_rdata, mem_enable, mem_rw,
               mem_byte, mem_addr, mem_wdata, err_timeout, dbg_state
    );

endinterface

// File: rtl/mem_port_arbiter_counter.sv
// MOC watchdog: counts cycles while enabled and flags the last allowed cycle.
module mem_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access with
// round-robin tie breaking and a MOC watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    state_t            state;
    req_id_t           last_gnt;
    req_id_t           gnt;
    req_id_t           pick;

    logic              mem_enable;
    logic              mem_rw;
    logic              mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              if_done;
    logic              dm_done;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              err_timeout;

    logic              expired;
    logic              cnt_clear;
    logic              cnt_enable;

    assign pick       = pick_grant(bus.if_req, bus.dm_req, last_gnt);
    assign cnt_enable = (state == ACCESS);
    assign cnt_clear  = (state != ACCESS) || bus.mem_moc || expired;

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_gnt    <= REQ_IF;
            gnt         <= REQ_IF;
            mem_enable  <= 1'b0;
            mem_rw      <= RW_READ;
            mem_byte    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_done     <= 1'b0;
            dm_done     <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if_done     <= 1'b0;
                    dm_done     <= 1'b0;
                    err_timeout <= 1'b0;
                    if (bus.if_req || bus.dm_req) begin
                        gnt        <= pick;
                        last_gnt   <= pick;
                        mem_enable <= 1'b1;
                        state      <= ACCESS;
                        if (pick == REQ_DM) begin
                            mem_rw    <= bus.dm_rw;
                            mem_byte  <= bus.dm_byte;
                            mem_addr  <= bus.dm_addr;
                            mem_wdata <= bus.dm_wdata;
                        end else begin
                            // Fetches are always word reads.
                            mem_rw    <= RW_READ;
                            mem_byte  <= 1'b0;
                            mem_addr  <= bus.if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // MOC takes priority over a watchdog expiry in the same cycle.
                    if (bus.mem_moc) begin
                        mem_enable <= 1'b0;
                        state      <= DONE;
                        if (gnt == REQ_DM) begin
                            dm_done <= 1'b1;
                            if (mem_rw == RW_READ) dm_rdata <= bus.mem_rdata;
                        end else begin
                            if_done <= 1'b1;
                            if (mem_rw == RW_READ) if_rdata <= bus.mem_rdata;
                        end
                    end else if (expired) begin
                        mem_enable  <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= DONE;
                        if (gnt == REQ_DM) begin
                            dm_done <= 1'b1;
                            if (mem_rw == RW_READ) dm_rdata <= '0;
                        end else begin
                            if_done <= 1'b1;
                            if (mem_rw == RW_READ) if_rdata <= '0;
                        end
                    end
                end
                DONE: begin
                    if_done     <= 1'b0;
                    dm_done     <= 1'b0;
                    err_timeout <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_enable  = mem_enable;
    assign bus.mem_rw      = mem_rw;
    assign bus.mem_byte    = mem_byte;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.if_done     = if_done;
    assign bus.dm_done     = dm_done;
    assign bus.if_rdata    = if_rdata;
    assign bus.dm_rdata    = dm_rdata;
    assign bus.err_timeout = err_timeout;
    assign bus.dbg_state   = state;

endmodule
